// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches operands, immediate and decoded control for EX,
// with write-back bypass, register-zero forcing and load-use bubble insertion.
module id_ex_stage #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int ALUOP_W = 4
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Flush,
   input  logic               Stall,
   input  logic               in_valid,
   input  logic [REG_AW-1:0]  Rs,
   input  logic [REG_AW-1:0]  Rt,
   input  logic [REG_AW-1:0]  Rd,
   input  logic [DATA_W-1:0]  Data1,
   input  logic [DATA_W-1:0]  Data2,
   input  logic [DATA_W-1:0]  Imm,
   input  logic               RegWrite_in,
   input  logic               MemRead_in,
   input  logic               MemWrite_in,
   input  logic               MemToReg_in,
   input  logic               ALUSrc_in,
   input  logic [ALUOP_W-1:0] ALUOp_in,
   input  logic               WB_RegWrite,
   input  logic [REG_AW-1:0]  WB_Rd,
   input  logic [DATA_W-1:0]  WB_Data,
   output logic               ex_valid,
   output logic [REG_AW-1:0]  ex_Rs,
   output logic [REG_AW-1:0]  ex_Rt,
   output logic [REG_AW-1:0]  ex_Rd,
   output logic [DATA_W-1:0]  ex_A,
   output logic [DATA_W-1:0]  ex_B,
   output logic [DATA_W-1:0]  ex_Imm,
   output logic               ex_RegWrite,
   output logic               ex_MemRead,
   output logic               ex_MemWrite,
   output logic               ex_MemToReg,
   output logic               ex_ALUSrc,
   output logic [ALUOP_W-1:0] ex_ALUOp,
   output logic               LoadUseStall
);

   // The register file writes on the same edge we sample, so a concurrent WB write is bypassed here.
   function automatic logic [DATA_W-1:0] operand_sel(
      input logic [REG_AW-1:0] addr,
      input logic [DATA_W-1:0] rf_data,
      input logic              wb_we,
      input logic [REG_AW-1:0] wb_rd,
      input logic [DATA_W-1:0] wb_data
   );
      if (addr == '0)
         return '0;
      else if (wb_we && (wb_rd == addr) && (wb_rd != '0))
         return wb_data;
      else
         return rf_data;
   endfunction

   logic [DATA_W-1:0]  w_a_p0;
   logic [DATA_W-1:0]  w_b_p0;
   logic               w_lus_p0;

   logic               r_vld_p1;
   logic [REG_AW-1:0]  r_rs_p1;
   logic [REG_AW-1:0]  r_rt_p1;
   logic [REG_AW-1:0]  r_rd_p1;
   logic [DATA_W-1:0]  r_a_p1;
   logic [DATA_W-1:0]  r_b_p1;
   logic [DATA_W-1:0]  r_imm_p1;
   logic               r_regwrite_p1;
   logic               r_memread_p1;
   logic               r_memwrite_p1;
   logic               r_memtoreg_p1;
   logic               r_alusrc_p1;
   logic [ALUOP_W-1:0] r_aluop_p1;

   assign w_a_p0 = operand_sel(Rs, Data1, WB_RegWrite, WB_Rd, WB_Data);
   assign w_b_p0 = operand_sel(Rt, Data2, WB_RegWrite, WB_Rd, WB_Data);

   // Rt is compared even for formats that don't read it; a spurious bubble is harmless.
   assign w_lus_p0 = in_valid & r_vld_p1 & r_memread_p1 & (r_rd_p1 != '0)
                   & ((r_rd_p1 == Rs) | (r_rd_p1 == Rt)) & ~Stall;

   // ID -> EX boundary
   always_ff @(posedge Clk) begin
      if (Reset || Flush || (!Stall && w_lus_p0)) begin
         r_vld_p1      <= 1'b0;
         r_rs_p1       <= '0;
         r_rt_p1       <= '0;
         r_rd_p1       <= '0;
         r_a_p1        <= '0;
         r_b_p1        <= '0;
         r_imm_p1      <= '0;
         r_regwrite_p1 <= 1'b0;
         r_memread_p1  <= 1'b0;
         r_memwrite_p1 <= 1'b0;
         r_memtoreg_p1 <= 1'b0;
         r_alusrc_p1   <= 1'b0;
         r_aluop_p1    <= '0;
      end else if (!Stall) begin
         r_vld_p1      <= in_valid;
         r_rs_p1       <= Rs;
         r_rt_p1       <= Rt;
         r_rd_p1       <= Rd;
         r_a_p1        <= w_a_p0;
         r_b_p1        <= w_b_p0;
         r_imm_p1      <= Imm;
         r_regwrite_p1 <= in_valid & RegWrite_in;
         r_memread_p1  <= in_valid & MemRead_in;
         r_memwrite_p1 <= in_valid & MemWrite_in;
         r_memtoreg_p1 <= in_valid & MemToReg_in;
         r_alusrc_p1   <= in_valid & ALUSrc_in;
         r_aluop_p1    <= in_valid ? ALUOp_in : '0;
      end
   end

   assign ex_valid     = r_vld_p1;
   assign ex_Rs        = r_rs_p1;
   assign ex_Rt        = r_rt_p1;
   assign ex_Rd        = r_rd_p1;
   assign ex_A         = r_a_p1;
   assign ex_B         = r_b_p1;
   assign ex_Imm       = r_imm_p1;
   assign ex_RegWrite  = r_regwrite_p1;
   assign ex_MemRead   = r_memread_p1;
   assign ex_MemWrite  = r_memwrite_p1;
   assign ex_MemToReg  = r_memtoreg_p1;
   assign ex_ALUSrc    = r_alusrc_p1;
   assign ex_ALUOp     = r_aluop_p1;
   assign LoadUseStall = w_lus_p0;

endmodule
